uart_regfile_handler: RTL
=========================

Name: uart_regfile_handler

Overview:
- Parametrised successor to the single-purpose UART command handler.
- Byte-stream command decoder and register file: host writes or reads any of NUM_REGS registers, each REG_BYTES bytes wide, over the UART byte interface.
- Sits between the existing uart_rx and uart_tx byte ports and the glitch engine, which consumes regs_o and the update strobes.
- Adds read-back, NAK on bad index, per-register update strobes and inter-byte timeout recovery.

Parameters:
- NUM_REGS, 4, number of registers; 1..128.
- REG_BYTES, 2, bytes per register; 1..4; register width W = 8*REG_BYTES.
- TIMEOUT_CYCLES, 50000, idle clocks allowed between payload bytes before a partial frame is discarded; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_data_i  in  8  received byte from uart_rx.
- rx_valid_i  in  1  one-cycle strobe: rx_data_i is valid.
- tx_data_o  out  8  byte to transmit.
- tx_valid_o  out  1  tx_data_o valid; held until accepted.
- tx_ready_i  in  1  uart_tx idle; a byte transfers on a clock edge where tx_valid_o and tx_ready_i are both 1.
- regs_o  out  NUM_REGS*W  packed registers; register i occupies bits [(i+1)*W-1 : i*W].
- update_o  out  NUM_REGS  one-cycle pulse per register on commit.
- busy_o  out  1  high when the FSM is not IDLE.
- timeout_o  out  1  one-cycle pulse when a partial frame is discarded.

Behaviour:
- Reset, asynchronous, rst_n low:
  - regs_o, update_o, tx_data_o, tx_valid_o, timeout_o all 0.
  - FSM to IDLE; byte counter and timeout counter to 0.
  - A frame in progress is discarded with no response.
- Command byte: bit7 = 1 for read, 0 for write; bits[6:0] = register index idx.
- FSM states: IDLE, WR_DATA, WR_DRAIN, RD_SEND, RESP.
- IDLE, on rx_valid_i:
  - Write, idx < NUM_REGS: go to WR_DATA, clear byte counter.
  - Write, idx >= NUM_REGS: go to WR_DRAIN.
  - Read, idx < NUM_REGS: load register idx into the tx shift register and go to RD_SEND.
  - Read, idx >= NUM_REGS: load NAK 0x15 and go to RESP.
- WR_DATA:
  - Payload arrives MSB first, shifted into an assembly register.
  - On the edge that samples byte REG_BYTES, register idx loads atomically (regs_o never shows a partial value) and update_o[idx] = 1 for the next cycle only.
  - Next state is RESP if an ack is queued (see ACK_EN), otherwise IDLE.
- WR_DRAIN:
  - Consumes REG_BYTES payload bytes with no register change.
  - Then loads NAK 0x15 and goes to RESP.
- RD_SEND:
  - Presents REG_BYTES bytes MSB first; each byte holds tx_valid_o = 1 until accepted.
  - Returns to IDLE on the handshake of the last byte.
- RESP: presents one byte; returns to IDLE on the handshake.
- rx_valid_i during RD_SEND or RESP: byte dropped; no state change.
- Timeout, WR_DATA and WR_DRAIN only:
  - Counter clears on each accepted byte and increments otherwise.
  - On reaching TIMEOUT_CYCLES: discard the partial frame, leave regs unchanged, pulse timeout_o, go to IDLE.
  - Counter is held at 0 in all other states.
- Index wrap: only idx bits [6:0] are decoded; no modulo is applied, so out-of-range indices always NAK.
- Simultaneous: the commit cycle and a new rx_valid_i cannot coincide, because uart_rx spaces bytes by at least one frame. If they do coincide, the new byte is dropped.
- busy_o = (state != IDLE), registered.

Optional Feature:
- Macro: UART_REGFILE_ACK_EN.
- Defined: after a successful write commit, the FSM goes to RESP and sends ACK 0x06.
- Undefined: a successful write returns straight to IDLE and sends nothing; NAK and read responses are unchanged.

Test Plan:
- Reset values: hold rst_n low mid-WR_DATA after 1 of 2 bytes -> regs_o all 0, tx_valid_o = 0, FSM in IDLE; then write 0x00,0x12,0x34 -> reg0 = 0x1234 and update_o[0] pulses exactly 1 cycle.
- Read-back: write 0x03,0xBE,0xEF, then send 0x83 with tx_ready_i high -> tx bytes 0xBE then 0xEF; all other regs unchanged.
- tx backpressure: read 0x83 with tx_ready_i low 20 cycles -> tx_valid_o = 1 and tx_data_o = 0xBE held stable the whole time; second byte appears only after the first handshake.
- Bad index: 0x85 -> single 0x15; write 0x07,0xAA,0xBB -> payload consumed, 0x15 sent, regs unchanged, no update_o.
- Timeout with TIMEOUT_CYCLES = 100: send 0x01,0x55 then idle 100 cycles -> timeout_o pulses, reg1 unchanged; next 0x81 reads the old reg1.
- ACK build with UART_REGFILE_ACK_EN defined: write 0x02,0x00,0x10 -> reg2 = 0x0010 and 0x06 transmitted; without the macro -> no tx activity.

Source files
------------

// File: rtl/uart_regfile_handler.sv
// Byte-stream command decoder and register file for uart_rx/uart_tx (write, read-back, NAK, timeout).
// Optional macro UART_REGFILE_ACK_EN: a successful write commit sends ACK 0x06.
module uart_regfile_handler #(
  parameter int NUM_REGS       = 4,
  parameter int REG_BYTES      = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [7:0]                      rx_data_i,
  input  logic                            rx_valid_i,
  output logic [7:0]                      tx_data_o,
  output logic                            tx_valid_o,
  input  logic                            tx_ready_i,
  output logic [NUM_REGS*8*REG_BYTES-1:0] regs_o,
  output logic [NUM_REGS-1:0]             update_o,
  output logic                            busy_o,
  output logic                            timeout_o
);
  localparam int         W       = 8 * REG_BYTES;
  localparam int         IDXW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] NREGS   = 8'(NUM_REGS);
  localparam logic [2:0] LAST    = 3'(REG_BYTES - 1);
  localparam bit         TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
  // Response bytes are placed in the top byte of the tx shift register.
  localparam logic [W-1:0] NAK_W = W'(8'h15) << (W - 8);
`ifdef UART_REGFILE_ACK_EN
  localparam logic [W-1:0] ACK_W = W'(8'h06) << (W - 8);
`endif

  typedef enum logic [2:0] {IDLE, WR_DATA, WR_DRAIN, RD_SEND, RESP} state_t;

  state_t                     state;
  logic [NUM_REGS-1:0][W-1:0] regs;
  logic [W-1:0]               asm_q, asm_nxt, tx_sh;
  logic [IDXW-1:0]            idx_q, rx_idx;
  logic [2:0]                 bcnt;
  logic [31:0]                to_cnt;
  logic                       cmd_ok, tx_hs;

  assign asm_nxt   = (asm_q << 8) | W'(rx_data_i);
  assign rx_idx    = rx_data_i[IDXW-1:0];
  assign cmd_ok    = {1'b0, rx_data_i[6:0]} < NREGS;
  assign tx_hs     = tx_valid_o & tx_ready_i;
  assign tx_data_o = tx_sh[W-1 -: 8];
  assign regs_o    = regs;
  assign busy_o    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      regs       <= '0;
      asm_q      <= '0;
      tx_sh      <= '0;
      idx_q      <= '0;
      bcnt       <= '0;
      to_cnt     <= '0;
      tx_valid_o <= 1'b0;
      update_o   <= '0;
      timeout_o  <= 1'b0;
    end else begin
      update_o  <= '0;
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (rx_valid_i) begin
            bcnt <= '0;
            if (!rx_data_i[7]) begin
              idx_q <= rx_idx;
              state <= cmd_ok ? WR_DATA : WR_DRAIN;
            end else if (cmd_ok) begin
              tx_sh      <= regs[rx_idx];
              tx_valid_o <= 1'b1;
              state      <= RD_SEND;
            end else begin
              tx_sh      <= NAK_W;
              tx_valid_o <= 1'b1;
              state      <= RESP;
            end
          end
        end
        WR_DATA, WR_DRAIN: begin
          if (rx_valid_i) begin
            to_cnt <= '0;
            bcnt   <= bcnt + 3'd1;
            asm_q  <= asm_nxt;
            if (bcnt == LAST) begin
              if (state == WR_DATA) begin
                // Whole word lands in one edge so regs_o never shows a partial value.
                regs[idx_q]     <= asm_nxt;
                update_o[idx_q] <= 1'b1;
`ifdef UART_REGFILE_ACK_EN
                tx_sh      <= ACK_W;
                tx_valid_o <= 1'b1;
                state      <= RESP;
`else
                state      <= IDLE;
`endif
              end else begin
                tx_sh      <= NAK_W;
                tx_valid_o <= 1'b1;
                state      <= RESP;
              end
            end
          end else if (TO_EN) begin
            if (to_cnt == TO_LAST) begin
              to_cnt    <= '0;
              timeout_o <= 1'b1;
              state     <= IDLE;
            end else begin
              to_cnt <= to_cnt + 32'd1;
            end
          end
        end
        RD_SEND: begin
          if (tx_hs) begin
            if (bcnt == LAST) begin
              tx_valid_o <= 1'b0;
              state      <= IDLE;
            end else begin
              bcnt  <= bcnt + 3'd1;
              tx_sh <= tx_sh << 8;
            end
          end
        end
        RESP: begin
          if (tx_hs) begin
            tx_valid_o <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
